apu_frame_sequencer: RTL and testbench
======================================

// Module: apu_frame_sequencer
// PURPOSE
//  Frame counter for the NES APU ($4017). Counts CPU-cycle enables and issues one-cycle quarter-frame
//  strobes (envelope/linear counter) and half-frame strobes (length/sweep) to every channel.
//  oQuarter_clk drives the triangle iLinear_clk input; oHalf_clk drives iLength_clk.
//  Supports 4-step and 5-step sequences, write-triggered resynchronisation and the frame IRQ.
// PARAMETERS
//  CNT_W      16     width of the CPU-cycle counter; must hold STEP5
//  STEP1      7457   CPU-cycle count of step 1
//  STEP2      14913  CPU-cycle count of step 2
//  STEP3      22371  CPU-cycle count of step 3
//  STEP4      29829  CPU-cycle count of step 4 (4-step terminal)
//  STEP5      37281  CPU-cycle count of step 5 (5-step terminal)
//  WR_DELAY   3      CPU-cycle enables from a $4017 write to the counter reset; must be >= 1
// PORTS
//  iClk         in   1  system clock
//  iReset_n     in   1  asynchronous reset, active low
//  iCpu_ce      in   1  one-iClk CPU-cycle enable; all counting advances only on it
//  iW           in   1  one-iClk write strobe for $4017
//  iRegister    in   8  $4017 data: [7]=mode (1=5-step), [6]=IRQ inhibit; other bits ignored
//  iIrq_ack     in   1  one-iClk strobe on a $4015 read; clears the frame IRQ flag
//  oQuarter_clk out  1  quarter-frame strobe, one iClk wide, coincident with an iCpu_ce cycle
//  oHalf_clk    out  1  half-frame strobe, one iClk wide, coincident with oQuarter_clk
//  oIrq         out  1  frame IRQ flag (level)
//  oStep        out  3  index of the last step fired: 0..5; 0 after reset or resync
// BEHAVIOUR
//  Reset (async): counter=0, mode=0, inhibit=0, pending=0, oQuarter_clk=0, oHalf_clk=0, oIrq=0, oStep=0.
//  Counter: +1 on each iCpu_ce. Steps fire on the iCpu_ce where the counter equals STEPn:
//   4-step: quarter at steps 1-4; half at 2 and 4; IRQ set at 4 when inhibit=0; counter<=0 at STEP4.
//   5-step: quarter at 1,2,3,5; half at 2 and 5; step 4 fires nothing; no IRQ; counter<=0 at STEP5.
//  Strobes are registered, so each asserts on the iClk edge after the qualifying iCpu_ce.
//  FSM: RUN -> PEND on iW (from any state).
//   The iW cycle loads mode and inhibit immediately. inhibit=1 clears oIrq on the same edge.
//   PEND counts WR_DELAY iCpu_ce enables and then returns to RUN.
//   On that last enable: counter<=0, oStep<=0; if mode=1, also emit one quarter strobe and one half strobe.
//   PEND keeps counting the old sequence, so steps that fall inside the delay still fire under the new mode.
//  Simultaneous events:
//   - iW during PEND restarts the delay with the new data.
//   - IRQ set and iIrq_ack on the same cycle: set wins.
//   - iW with inhibit=0 does not clear oIrq.
//   - Step boundary coinciding with the PEND expiry: the expiry reset wins; the step does not fire.
//     In 5-step mode only the expiry pulse is emitted.
//  Counter never exceeds the terminal step value; no wrap beyond 2^CNT_W.
// CONFIGURATION
//  APU_FRAME_IRQ_EN defined: IRQ flag, inhibit bit and iIrq_ack behave as above.
//  APU_FRAME_IRQ_EN undefined: no flag register; oIrq tied 0; iRegister[6] and iIrq_ack ignored.
// STRUCTURE
//  Shared package apu_pkg:
//   - frame step constants STEP1..STEP5
//   - mode enum {FRAME_4STEP, FRAME_5STEP}
//   - FSM state enum {FS_RUN, FS_PEND}
//  Single module. No sub-module is natural: the step decode is a small compare of the counter
//  against the constants, and the delay is a 2-bit counter.
// TESTING (iCpu_ce every 2nd iClk unless stated)
//  1. Reset, no writes -> quarter strobes at ce counts 7457/14913/22371/29829; half at 14913 and 29829;
//     oIrq=1 after 29829; next quarter at ce count 7457 after the wrap.
//  2. Write 8'h80 -> after 3 ce, immediate quarter+half pulse, oStep=0; then quarter at counts
//     7457/14913/22371/37281, half at 14913/37281; no pulse at 29829; oIrq stays 0.
//  3. oIrq=1, then write 8'h40 -> oIrq=0 on the write edge; next 4-step cycle leaves oIrq=0.
//     Then pulse iIrq_ack with inhibit=0 and oIrq=1 -> oIrq=0.
//  4. Assert iIrq_ack on the exact ce of step 4 -> oIrq=1 (set wins).
//     Second iW arriving 1 ce after the first -> reset occurs 3 ce after the second write.
//  5. Assert iReset_n=0 mid-sequence (counter ~20000, PEND active) -> all outputs 0 asynchronously.
//     After release, the first quarter strobe comes at ce count 7457.
//  6. Build without APU_FRAME_IRQ_EN, rerun scenario 1 -> identical strobes, oIrq constant 0.

Source files
------------

// File: rtl/apu_pkg.sv
// apu_pkg: shared frame-sequencer step constants, sequence mode and FSM state enums
package apu_pkg;
  localparam int STEP1 = 7457;
  localparam int STEP2 = 14913;
  localparam int STEP3 = 22371;
  localparam int STEP4 = 29829;
  localparam int STEP5 = 37281;
  typedef enum logic {FRAME_4STEP, FRAME_5STEP} frame_mode_e;
  typedef enum logic {FS_RUN, FS_PEND} frame_state_e;
endpackage

// File: rtl/apu_frame_sequencer.sv
// apu_frame_sequencer: NES APU $4017 frame counter issuing quarter/half-frame strobes and the frame IRQ.
// Define APU_FRAME_IRQ_EN to build the IRQ flag, inhibit bit and $4015 acknowledge; otherwise oIrq is 0.
module apu_frame_sequencer #(
  parameter int CNT_W    = 16,
  parameter int STEP1    = apu_pkg::STEP1,
  parameter int STEP2    = apu_pkg::STEP2,
  parameter int STEP3    = apu_pkg::STEP3,
  parameter int STEP4    = apu_pkg::STEP4,
  parameter int STEP5    = apu_pkg::STEP5,
  parameter int WR_DELAY = 3
) (
  input  logic       iClk,
  input  logic       iReset_n,
  input  logic       iCpu_ce,
  input  logic       iW,
  input  logic [7:0] iRegister,
  input  logic       iIrq_ack,
  output logic       oQuarter_clk,
  output logic       oHalf_clk,
  output logic       oIrq,
  output logic [2:0] oStep
);
  import apu_pkg::*;
  frame_state_e state_q, state_d;
  frame_mode_e mode_q, mode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_nx;
  logic [1:0] dly_q, dly_d;
  logic quarter_q, quarter_d, half_q, half_d;
  logic [2:0] step_q, step_d;
  logic irq_set, expire, five;
  logic unused_w;
  assign cnt_nx = cnt_q + 1'b1;
  assign five = mode_q == FRAME_5STEP;
  // A new write restarts the delay, so it pre-empts an expiry on the same cycle
  assign expire = iCpu_ce && !iW && state_q == FS_PEND && dly_q == 2'(WR_DELAY - 1);
  always_comb begin
    state_d = state_q;
    mode_d = mode_q;
    cnt_d = cnt_q;
    dly_d = dly_q;
    quarter_d = 1'b0;
    half_d = 1'b0;
    step_d = step_q;
    irq_set = 1'b0;
    if (expire) begin
      cnt_d = '0;
      step_d = 3'd0;
      state_d = FS_RUN;
      quarter_d = five;
      half_d = five;
    end else if (iCpu_ce) begin
      cnt_d = cnt_nx;
      dly_d = state_q == FS_PEND ? dly_q + 2'd1 : dly_q;
      if (cnt_nx == CNT_W'(STEP1)) begin
        quarter_d = 1'b1;
        step_d = 3'd1;
      end else if (cnt_nx == CNT_W'(STEP2)) begin
        quarter_d = 1'b1;
        half_d = 1'b1;
        step_d = 3'd2;
      end else if (cnt_nx == CNT_W'(STEP3)) begin
        quarter_d = 1'b1;
        step_d = 3'd3;
      end else if (cnt_nx == CNT_W'(STEP4) && !five) begin
        quarter_d = 1'b1;
        half_d = 1'b1;
        step_d = 3'd4;
        cnt_d = '0;
        irq_set = 1'b1;
      end else if (cnt_nx == CNT_W'(STEP5) && five) begin
        quarter_d = 1'b1;
        half_d = 1'b1;
        step_d = 3'd5;
        cnt_d = '0;
      end
    end
    if (iW) begin
      state_d = FS_PEND;
      dly_d = 2'd0;
      mode_d = iRegister[7] ? FRAME_5STEP : FRAME_4STEP;
    end
  end
  always_ff @(posedge iClk or negedge iReset_n)
    if (!iReset_n) begin
      state_q <= FS_RUN;
      mode_q <= FRAME_4STEP;
      cnt_q <= '0;
      dly_q <= 2'd0;
      quarter_q <= 1'b0;
      half_q <= 1'b0;
      step_q <= 3'd0;
    end else begin
      state_q <= state_d;
      mode_q <= mode_d;
      cnt_q <= cnt_d;
      dly_q <= dly_d;
      quarter_q <= quarter_d;
      half_q <= half_d;
      step_q <= step_d;
    end
  assign oQuarter_clk = quarter_q;
  assign oHalf_clk = half_q;
  assign oStep = step_q;
`ifdef APU_FRAME_IRQ_EN
  logic inh_q, irq_q;
  // Inhibit write clears the flag outright; otherwise a step-4 set beats an acknowledge
  always_ff @(posedge iClk or negedge iReset_n)
    if (!iReset_n) begin
      inh_q <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      inh_q <= iW ? iRegister[6] : inh_q;
      irq_q <= !(iW && iRegister[6]) && ((irq_set && !inh_q) || (irq_q && !iIrq_ack));
    end
  assign oIrq = irq_q;
  assign unused_w = ^iRegister[5:0];
`else
  assign oIrq = 1'b0;
  assign unused_w = ^{iRegister[6:0], iIrq_ack, irq_set};
`endif
endmodule

// File: tb/tb_apu_frame_sequencer.sv
// tb_apu_frame_sequencer: directed scoreboard bench with shortened step constants; strobes checked by a monitor.
module tb_apu_frame_sequencer;
  localparam int S1 = 7, S2 = 14, S3 = 22, S4 = 29, S5 = 37;
`ifdef APU_FRAME_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b1, ce = 1'b0, w = 1'b0, ack = 1'b0;
  logic [7:0] reg_v = 8'h00;
  logic q, h, irq;
  logic [2:0] st;
  int ce_n = 0, errors = 0, checks = 0;
  typedef struct {int ce; logic hh; logic [2:0] st;} ev_t;
  ev_t exp_q[$];
  always #5 clk = ~clk;
  apu_frame_sequencer #(.CNT_W(8), .STEP1(S1), .STEP2(S2), .STEP3(S3), .STEP4(S4), .STEP5(S5), .WR_DELAY(3)) dut (
    .iClk(clk), .iReset_n(rst_n), .iCpu_ce(ce), .iW(w), .iRegister(reg_v), .iIrq_ack(ack),
    .oQuarter_clk(q), .oHalf_clk(h), .oIrq(irq), .oStep(st)
  );
  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask
  task automatic ex(int c, logic hh, logic [2:0] s);
    exp_q.push_back('{c, hh, s});
  endtask
  task automatic tick(int n);
    repeat (n) begin
      @(negedge clk); ce = 1'b1; ce_n++;
      @(negedge clk); ce = 1'b0;
    end
  endtask
  task automatic tick_ack();
    @(negedge clk); ce = 1'b1; ack = 1'b1; ce_n++;
    @(negedge clk); ce = 1'b0; ack = 1'b0;
  endtask
  task automatic wr(logic [7:0] d);
    @(negedge clk); w = 1'b1; reg_v = d;
    @(negedge clk); w = 1'b0;
  endtask
  always @(negedge clk) begin : monitor
    ev_t e;
    if (q || h) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: ce=%0d quarter=%0b half=%0b step=%0d", ce_n, q, h, st);
      end else begin
        e = exp_q.pop_front();
        chk("strobe_ce", ce_n, e.ce);
        chk("strobe_quarter", {31'd0, q}, 1);
        chk("strobe_half", {31'd0, h}, {31'd0, e.hh});
        chk("strobe_step", {29'd0, st}, {29'd0, e.st});
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL timeout: ce=%0d", ce_n);
    $fatal(1);
  end
  initial begin
    #1 rst_n = 1'b0;
    #10;
    chk("rst_quarter", {31'd0, q}, 0);
    chk("rst_half", {31'd0, h}, 0);
    chk("rst_irq", {31'd0, irq}, 0);
    chk("rst_step", {29'd0, st}, 0);
    @(negedge clk) rst_n = 1'b1;
    // 4-step free run, wrap into the next frame
    ex(7, 0, 1); ex(14, 1, 2); ex(22, 0, 3); ex(29, 1, 4); ex(36, 0, 1);
    tick(29);
    chk("s1_irq", {31'd0, irq}, {31'd0, IRQ_ON});
    chk("s1_step4", {29'd0, st}, 4);
    tick(11);
    chk("s1_queue", exp_q.size(), 0);
    // 5-step write; expiry lands on the STEP2 boundary, only the expiry pulse fires
    ex(43, 1, 0); ex(50, 0, 1); ex(57, 1, 2); ex(65, 0, 3); ex(80, 1, 5);
    wr(8'h80);
    tick(3);
    chk("s2_step_resync", {29'd0, st}, 0);
    tick(40);
    chk("s2_irq_kept", {31'd0, irq}, {31'd0, IRQ_ON});
    chk("s2_step5", {29'd0, st}, 5);
    chk("s2_queue", exp_q.size(), 0);
    // inhibit write clears IRQ at once; 4-step expiry emits nothing
    wr(8'h40);
    chk("s3_irq_inhibit", {31'd0, irq}, 0);
    tick(3);
    chk("s3_step_resync", {29'd0, st}, 0);
    ex(93, 0, 1); ex(100, 1, 2); ex(108, 0, 3); ex(115, 1, 4);
    tick(30);
    chk("s3_irq_inhibited", {31'd0, irq}, 0);
    ex(126, 0, 1); ex(133, 1, 2); ex(141, 0, 3); ex(148, 1, 4);
    wr(8'h00);
    tick(32);
    chk("s3_irq_set", {31'd0, irq}, {31'd0, IRQ_ON});
    @(negedge clk) ack = 1'b1;
    @(negedge clk) ack = 1'b0;
    chk("s3_irq_ack", {31'd0, irq}, 0);
    chk("s3_queue", exp_q.size(), 0);
    // ack on the step-4 enable: set wins; then a second write restarts the delay
    ex(155, 0, 1); ex(162, 1, 2); ex(170, 0, 3); ex(177, 1, 4);
    tick(28);
    tick_ack();
    chk("s4_irq_set_wins", {31'd0, irq}, {31'd0, IRQ_ON});
    wr(8'h00);
    tick(1);
    ex(181, 1, 0); ex(188, 0, 1);
    wr(8'h80);
    tick(3);
    chk("s4_step_resync", {29'd0, st}, 0);
    tick(8);
    chk("s4_queue", exp_q.size(), 0);
    // async reset mid-sequence with a write pending
    ex(195, 1, 2);
    tick(10);
    wr(8'h00);
    tick(1);
    chk("s5_step_before", {29'd0, st}, 2);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("s5_async_step", {29'd0, st}, 0);
    chk("s5_async_irq", {31'd0, irq}, 0);
    chk("s5_async_quarter", {31'd0, q}, 0);
    chk("s5_async_half", {31'd0, h}, 0);
    @(negedge clk) rst_n = 1'b1;
    ex(207, 0, 1);
    tick(8);
    chk("s5_step_after", {29'd0, st}, 1);
    chk("s5_irq_after", {31'd0, irq}, 0);
    chk("s5_queue", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
